// File: rtl/byte_serial_add32_pkg.sv
// Shared package for the byte-serial adder.
// Holds the byte slice width and the controller state encoding used by
// byte_serial_add32 and its 8-bit carry-lookahead slice adder.
package byte_serial_add32_pkg;

    localparam int SLICE = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/byte_serial_add32_cla_8.sv
// 8-bit carry-lookahead adder slice.
// Ports:
//   a, b : slice operands
//   ci   : carry into bit 0
//   sum  : slice sum
//   co   : carry out of bit 7
module byte_serial_add32_cla_8
    import byte_serial_add32_pkg::*;
(
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             ci,
    output logic [SLICE-1:0] sum,
    output logic             co
);

    logic [SLICE-1:0] g;
    logic [SLICE-1:0] p;
    logic [SLICE:0]   c;
    logic             pp;

    // Each carry is expanded as a flat sum of generate terms qualified by
    // the propagates above them, so no carry depends on a lower carry.
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        pp   = 1'b0;
        c[0] = ci;
        for (int i = 1; i <= SLICE; i++) begin
            c[i] = g[i-1];
            pp   = p[i-1];
            for (int j = i - 2; j >= 0; j--) begin
                c[i] = c[i] | (pp & g[j]);
                pp   = pp & p[j];
            end
            c[i] = c[i] | (pp & ci);
        end
        sum = p ^ c[SLICE-1:0];
        co  = c[SLICE];
    end

endmodule

// File: rtl/byte_serial_add32.sv
// Byte-serial WIDTH-bit adder with valid/ready handshakes on both sides.
// One operand pair is accepted in IDLE, added one byte per cycle through a
// single 8-bit CLA (NBYTES cycles), then held in DONE until outReady.
// Ports:
//   clk, rstN          : clock, synchronous active-low reset
//   inValid / inReady  : operand handshake (inReady only in IDLE)
//   x, y, cIn          : operands and carry-in
//   sub                : subtract request (only with BYTE_SERIAL_ADD32_SUB_EN)
//   outValid / outReady: result handshake
//   s, cOut, ovf       : sum, carry out of MSB, signed overflow
// Build option: define BYTE_SERIAL_ADD32_SUB_EN to add port sub and the
// operand inversion for subtraction; otherwise the block only adds.
module byte_serial_add32
    import byte_serial_add32_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cIn,
`ifdef BYTE_SERIAL_ADD32_SUB_EN
    input  logic             sub,
`endif
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] s,
    output logic             cOut,
    output logic             ovf
);

    localparam int NBYTES = WIDTH / SLICE;
    localparam int KW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NBYTES - 1);

    state_e           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             ovf_q, ovf_d;
    logic             ready_q, ready_d;

    logic             sub_w;
    logic [SLICE-1:0] slice_x;
    logic [SLICE-1:0] slice_y;
    logic [SLICE-1:0] slice_sum;
    logic             slice_co;

`ifdef BYTE_SERIAL_ADD32_SUB_EN
    assign sub_w = sub;
`else
    assign sub_w = 1'b0;
`endif

    // Byte-k operand select feeding the single slice adder.
    always_comb begin
        slice_x = '0;
        slice_y = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (k_q == KW'(i)) begin
                slice_x = x_q[i*SLICE +: SLICE];
                slice_y = y_q[i*SLICE +: SLICE];
            end
        end
    end

    byte_serial_add32_cla_8 u_cla (
        .a   (slice_x),
        .b   (slice_y),
        .ci  (carry_q),
        .sum (slice_sum),
        .co  (slice_co)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        carry_d = carry_q;
        x_d     = x_q;
        y_d     = y_q;
        s_d     = s_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (inValid && ready_q) begin
                    x_d     = x;
                    // Subtraction is x + ~y + 1: invert y and force carry-in.
                    y_d     = sub_w ? ~y : y;
                    carry_d = sub_w ? 1'b1 : cIn;
                    k_d     = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                carry_d = slice_co;
                for (int i = 0; i < NBYTES; i++) begin
                    if (k_q == KW'(i)) begin
                        s_d[i*SLICE +: SLICE] = slice_sum;
                    end
                end
                k_d = k_q + KW'(1);
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = DONE;
                    // Sum MSB comes straight from the top slice this cycle.
                    ovf_d   = (x_q[WIDTH-1] == y_q[WIDTH-1]) &&
                              (slice_sum[SLICE-1] != x_q[WIDTH-1]);
                end
            end
            DONE: begin
                if (outReady) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Registered so inReady stays low for the reset cycle itself.
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q <= IDLE;
            k_q     <= '0;
            carry_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            s_q     <= '0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            x_q     <= x_d;
            y_q     <= y_d;
            s_q     <= s_d;
            ovf_q   <= ovf_d;
            ready_q <= ready_d;
        end
    end

    assign inReady  = ready_q;
    assign outValid = (state_q == DONE);
    assign s        = s_q;
    assign cOut     = carry_q;
    assign ovf      = ovf_q;

endmodule

// File: doc/byte_serial_add32.md
BYTE_SERIAL_ADD32 -- requirements
Module: byte_serial_add32

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits; legal values are multiples of 8 and at least 8.
REQ-002 SHALL have derived localparam NBYTES = WIDTH/8, the number of byte slices, which also equals the latency in cycles.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rstN, input, 1 bit: synchronous active-low reset.
REQ-005 SHALL have port inValid, input, 1 bit: operands are presented.
REQ-006 SHALL have port inReady, output, 1 bit: block can accept operands.
REQ-007 SHALL have ports x and y, input, WIDTH bits each: the operands.
REQ-008 SHALL have port cIn, input, 1 bit: carry-in.
REQ-009 SHALL have port sub, input, 1 bit: subtract request; present only with SUB_EN.
REQ-010 SHALL have port outValid, output, 1 bit: result is valid.
REQ-011 SHALL have port outReady, input, 1 bit: downstream accepts the result.
REQ-012 SHALL have port s, output, WIDTH bits: the sum.
REQ-013 SHALL have port cOut, output, 1 bit: carry out of the MSB.
REQ-014 SHALL have port ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-015 SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-016 inReady SHALL be 1 only in IDLE; an accept occurs when inValid and inReady are both 1 at an edge.
REQ-017 On accept, the block SHALL latch x, y (y inverted when sub=1) and a carry register (cIn, or 1 when sub=1), clear byte index k, and enter BUSY.
REQ-018 In BUSY, each cycle SHALL add slice k of the latched operands with the carry register through one 8-bit CLA, write the result into byte k of s, load the carry register with the slice carry-out, and increment k.
REQ-019 When k = NBYTES-1, the block SHALL enter DONE at that edge; outValid SHALL rise exactly NBYTES cycles after the accept edge.
REQ-020 In DONE: outValid=1; s, cOut and ovf SHALL be held stable until an edge with outReady=1, after which the state returns to IDLE.
REQ-021 There SHALL be no overlap: a new accept is possible only in the cycle after the result handshake.
REQ-022 cOut SHALL equal the final carry register value; with sub=1, cOut=1 means no borrow.
REQ-023 ovf SHALL be computed as (xMSB == y'MSB) and (sMSB != xMSB), where y' is the possibly inverted y.
REQ-024 In IDLE and BUSY, outValid SHALL be 0; s, cOut and ovf are don't-care but SHALL NOT change in IDLE.
REQ-025 Input changes while not in IDLE SHALL be ignored.

Reset
REQ-026 While rstN=0 at an edge: state=IDLE, k=0, carry register=0, s=0, cOut=0, ovf=0, outValid=0.
REQ-027 inReady SHALL read 0 during the reset cycle and 1 from the first edge with rstN=1.
REQ-028 Reset asserted in BUSY or DONE SHALL abort the operation and produce no outValid pulse.

Configuration
REQ-029 With macro BYTE_SERIAL_ADD32_SUB_EN defined, port sub and the operand inversion SHALL exist.
REQ-030 Without BYTE_SERIAL_ADD32_SUB_EN, port sub SHALL be absent and the block SHALL behave as if sub=0; latency SHALL be unchanged.

Structure
REQ-031 The FSM state encoding typedef and the SLICE=8 constant SHALL live in the shared FPU package.
REQ-032 The byte adder SHALL be one instance of the existing CLA_8 sub-module, driven by a mux over the latched operands selected by k; no other sub-modules.

Verification
REQ-033 Carry chain: x=0xFFFFFFFF, y=0x00000000, cIn=1 -> s=0x00000000, cOut=1, ovf=0, outValid rises 4 cycles after accept.
REQ-034 Overflow: x=0x7FFFFFFF, y=0x00000001, cIn=0 -> s=0x80000000, cOut=0, ovf=1.
REQ-035 Subtract (SUB_EN): x=5, y=7, sub=1 -> s=0xFFFFFFFE, cOut=0, ovf=0; with x=7, y=5 -> s=2, cOut=1.
REQ-036 Backpressure: hold outReady=0 for 3 cycles in DONE -> s, cOut, ovf and outValid stay stable and inReady=0; outReady=1 -> IDLE next cycle, inReady=1.
REQ-037 Reset: rstN=0 on the second BUSY cycle -> next cycle outValid=0 and s=0, with no result ever emitted; a new accept after release yields a correct result.
REQ-038 Back-to-back: inValid held high with 3 operand pairs and outReady=1 -> 3 results, each spaced NBYTES+2 cycles apart, all correct.
